wb_ntp_arbiter: RTL

WB_NTP_ARBITER -- requirements
Module: wb_ntp_arbiter

---
 rtl/wb_ntp_pkg.sv | 26 ++
 rtl/wb_ntp_wdog.sv | 50 +++++
 rtl/wb_ntp_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/wb_ntp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_ntp_pkg
// Description : Shared types and constants for the NTP Wishbone arbiter.
//               Holds the arbiter state enumeration (encoded so the state
//               register doubles as the one-hot grant vector), bus widths
//               and the default wait timeout.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_ntp_pkg;

  localparam int WB_ADR_W        = 6;
  localparam int WB_DAT_W        = 32;
  localparam int WB_SEL_W        = WB_DAT_W / 8;
  localparam int TIMEOUT_DEFAULT = 255;
  localparam int WDOG_W          = 8;

  // Encoding equals the grant vector: IDLE=00, GNT0=01, GNT1=10.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_GNT0 = 2'b01,
    ST_GNT1 = 2'b10
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/wb_ntp_wdog.sv
`default_nettype none
// ============================================================================
// Module      : wb_ntp_wdog
// Description : Slave-ack wait counter for the NTP arbiter. Counts cycles a
//               granted strobe waits for ack, saturating at TIMEOUT, and
//               flags timeout_hit in the cycle the count reaches TIMEOUT-1.
// Ports       : i_clk         - clock
//               i_rst_n       - asynchronous active-low reset
//               i_clr         - grant is changing at the next edge
//               i_ack         - slave ack
//               i_stb         - strobe of the currently granted master
//               o_timeout_hit - terminate the current strobe with an error
// Revision    : 1.0 - initial release
// ============================================================================
module wb_ntp_wdog
  import wb_ntp_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_ack,
  input  logic i_stb,
  output logic o_timeout_hit
);

  localparam logic [WDOG_W-1:0] c_cnt_max = WDOG_W'(TIMEOUT);
  localparam logic [WDOG_W-1:0] c_cnt_hit = WDOG_W'(TIMEOUT - 1);

  logic [WDOG_W-1:0] r_cnt;

  // Clearing on the edge where the grant changes means a new owner always
  // starts its first cycle with a zero count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || i_ack || !i_stb) begin
      r_cnt <= '0;
    end else if (r_cnt != c_cnt_max) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Saturation past TIMEOUT-1 guarantees a single-cycle pulse; a
  // simultaneous ack always wins over the timeout.
  assign o_timeout_hit = (r_cnt == c_cnt_hit) && i_stb && !i_ack;

endmodule
`default_nettype wire

// File: rtl/wb_ntp_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_ntp_arbiter
// Description : Two-master Wishbone arbiter in front of the NTP register
//               slave. Master 0 is the CPU, master 1 the hardware timestamp
//               engine. Round-robin on ties, grant held for the whole cyc
//               (keeps 64-bit two-word accesses atomic), direct hand-over
//               between masters without an idle bubble, and a wait-timeout
//               that terminates an unanswered strobe with an error.
// Ports       : i_clk, i_rst_n        - clock, async active-low reset
//               i_m0_* / o_m0_*       - master 0 request / response
//               i_m1_* / o_m1_*       - master 1 request / response
//               o_s_* / i_s_*         - slave request / response
//               o_grant               - one-hot owner, 00 = idle
// Revision    : 1.0 - initial release
// ============================================================================
module wb_ntp_arbiter
  import wb_ntp_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  // master 0 (CPU)
  input  logic [WB_ADR_W-1:0] i_m0_adr,
  input  logic [WB_DAT_W-1:0] i_m0_dat,
  input  logic [WB_SEL_W-1:0] i_m0_sel,
  input  logic                i_m0_we,
  input  logic                i_m0_cyc,
  input  logic                i_m0_stb,
  output logic                o_m0_ack,
  output logic                o_m0_err,
  output logic [WB_DAT_W-1:0] o_m0_rdt,
  // master 1 (timestamp engine)
  input  logic [WB_ADR_W-1:0] i_m1_adr,
  input  logic [WB_DAT_W-1:0] i_m1_dat,
  input  logic [WB_SEL_W-1:0] i_m1_sel,
  input  logic                i_m1_we,
  input  logic                i_m1_cyc,
  input  logic                i_m1_stb,
  output logic                o_m1_ack,
  output logic                o_m1_err,
  output logic [WB_DAT_W-1:0] o_m1_rdt,
  // slave
  output logic [WB_ADR_W-1:0] o_s_adr,
  output logic [WB_DAT_W-1:0] o_s_dat,
  output logic [WB_SEL_W-1:0] o_s_sel,
  output logic                o_s_we,
  output logic                o_s_cyc,
  output logic                o_s_stb,
  input  logic                i_s_ack,
  input  logic [WB_DAT_W-1:0] i_s_rdt,
  // arbitration status
  output logic [1:0]          o_grant
);

  arb_state_t r_state;
  logic       r_last_owner;

  logic w_gnt0;
  logic w_gnt1;
  logic w_grant_chg;
  logic w_gnt_cyc;
  logic w_gnt_stb;
  logic w_timeout_hit;

  assign w_gnt0  = (r_state == ST_GNT0);
  assign w_gnt1  = (r_state == ST_GNT1);
  assign o_grant = r_state;

  // Arbitration FSM; last_owner resets to 1 so master 0 wins the first tie.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_last_owner <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_m0_cyc && (!i_m1_cyc || r_last_owner)) begin
            r_state      <= ST_GNT0;
            r_last_owner <= 1'b0;
          end else if (i_m1_cyc) begin
            r_state      <= ST_GNT1;
            r_last_owner <= 1'b1;
          end
        end
        ST_GNT0: begin
          if (!i_m0_cyc) begin
            if (i_m1_cyc) begin
              r_state      <= ST_GNT1;
              r_last_owner <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_GNT1: begin
          if (!i_m1_cyc) begin
            if (i_m0_cyc) begin
              r_state      <= ST_GNT0;
              r_last_owner <= 1'b0;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // The grant moves at the next edge exactly when idle with a request
  // pending, or when the current owner has released cyc.
  assign w_grant_chg = ((r_state == ST_IDLE) && (i_m0_cyc || i_m1_cyc)) ||
                       (w_gnt0 && !i_m0_cyc) ||
                       (w_gnt1 && !i_m1_cyc);

  always_comb begin
    o_s_adr   = '0;
    o_s_dat   = '0;
    o_s_sel   = '0;
    o_s_we    = 1'b0;
    w_gnt_cyc = 1'b0;
    w_gnt_stb = 1'b0;
    if (w_gnt0) begin
      o_s_adr   = i_m0_adr;
      o_s_dat   = i_m0_dat;
      o_s_sel   = i_m0_sel;
      o_s_we    = i_m0_we;
      w_gnt_cyc = i_m0_cyc;
      w_gnt_stb = i_m0_stb;
    end else if (w_gnt1) begin
      o_s_adr   = i_m1_adr;
      o_s_dat   = i_m1_dat;
      o_s_sel   = i_m1_sel;
      o_s_we    = i_m1_we;
      w_gnt_cyc = i_m1_cyc;
      w_gnt_stb = i_m1_stb;
    end
  end

  wb_ntp_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_clr         (w_grant_chg),
    .i_ack         (i_s_ack),
    .i_stb         (w_gnt_stb),
    .o_timeout_hit (w_timeout_hit)
  );

  // The timed-out strobe is withdrawn from the slave in the error cycle.
  assign o_s_cyc  = w_gnt_cyc;
  assign o_s_stb  = w_gnt_stb && !w_timeout_hit;

  assign o_m0_ack = i_s_ack && w_gnt0 && !w_timeout_hit;
  assign o_m1_ack = i_s_ack && w_gnt1 && !w_timeout_hit;
  assign o_m0_err = w_gnt0 && w_timeout_hit;
  assign o_m1_err = w_gnt1 && w_timeout_hit;

  assign o_m0_rdt = i_s_rdt;
  assign o_m1_rdt = i_s_rdt;

endmodule
`default_nettype wire
